// File: rtl/bnn_pkg.sv
// Shared types and width helpers for the binarised neural-network layer.
package bnn_pkg;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } bnn_state_e;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  // Accumulator width: must hold the full vector length L = in_w*beats.
  function automatic int cnt_w(input int in_w, input int beats);
    return $clog2(in_w * beats + 1);
  endfunction

  function automatic int pcnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic int addr_w(input int neurons, input int beats);
    return clog2_min1(neurons * beats + neurons);
  endfunction

  // Thresholds start right after the weight words.
  function automatic int thr_base(input int neurons, input int beats);
    return neurons * beats;
  endfunction

endpackage

// File: rtl/bnn_layer_if.sv
// Config, input-beat and result bundle for bnn_layer; out_popcnt exists only with BNN_LAYER_POPCNT_EN.
interface bnn_layer_if
  import bnn_pkg::*;
#(
  parameter int IN_W    = 8,
  parameter int BEATS   = 4,
  parameter int NEURONS = 4
) ();
  localparam int AW    = addr_w(NEURONS, BEATS);
  localparam int CNT_W = cnt_w(IN_W, BEATS);

  logic                cfg_we;
  logic [AW-1:0]       cfg_addr;
  logic [IN_W-1:0]     cfg_data;
  logic                cfg_busy;
  logic                in_valid;
  logic                in_ready;
  logic [IN_W-1:0]     in_data;
  logic                out_valid;
  logic                out_ready;
  logic [NEURONS-1:0]  out_data;
`ifdef BNN_LAYER_POPCNT_EN
  logic [NEURONS*CNT_W-1:0] out_popcnt;

  modport master (
    output cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready,
    input  cfg_busy, in_ready, out_valid, out_data, out_popcnt
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready,
    output cfg_busy, in_ready, out_valid, out_data, out_popcnt
  );
`else
  modport master (
    output cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready,
    input  cfg_busy, in_ready, out_valid, out_data
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready,
    output cfg_busy, in_ready, out_valid, out_data
  );
`endif

endinterface

// File: rtl/bnn_xnor_popcnt.sv
// Combinational XNOR of one activation beat against one weight word, then popcount of matches.
module bnn_xnor_popcnt #(
  parameter int W = 8
) (
  input  logic [W-1:0]           a_i,
  input  logic [W-1:0]           b_i,
  output logic [$clog2(W+1)-1:0] cnt_o
);
  localparam int PW = $clog2(W + 1);

  logic [W-1:0] match;

  assign match = ~(a_i ^ b_i);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) begin
      cnt_o = cnt_o + PW'(match[i]);
    end
  end

endmodule

// File: rtl/bnn_layer.sv
// Binary NN layer: BEATS beats per vector, result one cycle after last beat, held until out_ready.
// Backpressure: in_ready low during HOLD and while a cfg write claims beat 0; option BNN_LAYER_POPCNT_EN.
module bnn_layer
  import bnn_pkg::*;
#(
  parameter int IN_W    = 8,
  parameter int BEATS   = 4,
  parameter int NEURONS = 4
) (
  input  logic       clk,
  input  logic       rst,
  bnn_layer_if.slave bus
);
  localparam int CNT_W = cnt_w(IN_W, BEATS);
  localparam int PW    = pcnt_w(IN_W);
  localparam int AW    = addr_w(NEURONS, BEATS);
  localparam int BW    = clog2_min1(BEATS);
  localparam int BASE  = thr_base(NEURONS, BEATS);

  if (CNT_W > IN_W) begin : g_cnt_w_check
    $error("bnn_layer: accumulator width exceeds IN_W");
  end

  bnn_state_e          state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [CNT_W-1:0]    acc_q [NEURONS];
  logic [CNT_W-1:0]    acc_d [NEURONS];
  logic [CNT_W-1:0]    sum   [NEURONS];
  logic [PW-1:0]       pc    [NEURONS];
  logic                out_valid_q, out_valid_d;
  logic [NEURONS-1:0]  out_data_q, out_data_d;
  logic [IN_W-1:0]     w_q   [NEURONS][BEATS];
  logic [CNT_W-1:0]    thr_q [NEURONS];
`ifdef BNN_LAYER_POPCNT_EN
  logic [NEURONS*CNT_W-1:0] popcnt_q, popcnt_d;
`endif

  logic in_ready;
  logic beat_fire;
  logic cfg_fire;
  logic last_beat;

  // A pending cfg write owns the beat-0 slot so weights never change mid-vector.
  assign in_ready  = (state_q == ST_ACC) && !(bus.cfg_we && (beat_q == '0));
  assign beat_fire = bus.in_valid && in_ready;
  assign cfg_fire  = bus.cfg_we && (state_q == ST_ACC) && (beat_q == '0);
  assign last_beat = (beat_q == BW'(BEATS - 1));

  for (genvar n = 0; n < NEURONS; n++) begin : g_neuron
    bnn_xnor_popcnt #(.W(IN_W)) u_pc (
      .a_i   (bus.in_data),
      .b_i   (w_q[n][beat_q]),
      .cnt_o (pc[n])
    );
  end

  always_comb begin
    for (int n = 0; n < NEURONS; n++) begin
      sum[n] = acc_q[n] + CNT_W'(pc[n]);
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef BNN_LAYER_POPCNT_EN
    popcnt_d    = popcnt_q;
`endif
    case (state_q)
      ST_ACC: begin
        if (beat_fire) begin
          if (last_beat) begin
            for (int n = 0; n < NEURONS; n++) begin
              out_data_d[n] = (sum[n] >= thr_q[n]);
              acc_d[n]      = '0;
`ifdef BNN_LAYER_POPCNT_EN
              popcnt_d[n*CNT_W +: CNT_W] = sum[n];
`endif
            end
            out_valid_d = 1'b1;
            beat_d      = '0;
            state_d     = ST_HOLD;
          end else begin
            acc_d  = sum;
            beat_d = BW'(beat_q + 1'b1);
          end
        end
      end
      default: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACC;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int n = 0; n < NEURONS; n++) begin
        acc_q[n] <= '0;
      end
`ifdef BNN_LAYER_POPCNT_EN
      popcnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      acc_q       <= acc_d;
`ifdef BNN_LAYER_POPCNT_EN
      popcnt_q    <= popcnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NEURONS; n++) begin
        thr_q[n] <= '0;
        for (int b = 0; b < BEATS; b++) begin
          w_q[n][b] <= '0;
        end
      end
    end else if (cfg_fire) begin
      for (int n = 0; n < NEURONS; n++) begin
        for (int b = 0; b < BEATS; b++) begin
          if (bus.cfg_addr == AW'(n * BEATS + b)) w_q[n][b] <= bus.cfg_data;
        end
        if (bus.cfg_addr == AW'(BASE + n)) thr_q[n] <= bus.cfg_data[CNT_W-1:0];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.cfg_busy  = (state_q == ST_HOLD) || (beat_q != '0);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
`ifdef BNN_LAYER_POPCNT_EN
  assign bus.out_popcnt = popcnt_q;
`endif

endmodule

// File: tb/tb_bnn_layer.sv
// Directed and randomised checks of bnn_layer against a whole-vector XNOR/popcount model.
module tb_bnn_layer;
  localparam int IN_W    = 8;
  localparam int BEATS   = 4;
  localparam int NEURONS = 4;
  localparam int L       = IN_W * BEATS;
  localparam int CNT_W   = $clog2(L + 1);
  localparam int AW      = $clog2(NEURONS * BEATS + NEURONS);
  localparam int WORDS   = NEURONS * BEATS;
  localparam int NADDR   = WORDS + NEURONS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [L-1:0] m_w   [NEURONS];
  int           m_thr [NEURONS];

  always #5 clk = ~clk;

  bnn_layer_if #(.IN_W(IN_W), .BEATS(BEATS), .NEURONS(NEURONS)) bus ();

  bnn_layer #(.IN_W(IN_W), .BEATS(BEATS), .NEURONS(NEURONS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < NEURONS; n++) begin
      m_w[n]   = '0;
      m_thr[n] = 0;
    end
  endtask

  task automatic model_cfg(input int addr, input logic [IN_W-1:0] data);
    if (addr < WORDS) m_w[addr / BEATS][(addr % BEATS) * IN_W +: IN_W] = data;
    else if (addr < NADDR) m_thr[addr - WORDS] = int'(data) % (1 << CNT_W);
  endtask

  function automatic logic [NEURONS-1:0] exp_bits(input logic [L-1:0] v);
    logic [NEURONS-1:0] r;
    for (int n = 0; n < NEURONS; n++) r[n] = ($countones(~(v ^ m_w[n])) >= m_thr[n]);
    return r;
  endfunction

  function automatic logic [NEURONS*CNT_W-1:0] exp_pc(input logic [L-1:0] v);
    logic [NEURONS*CNT_W-1:0] r;
    for (int n = 0; n < NEURONS; n++) r[n*CNT_W +: CNT_W] = CNT_W'($countones(~(v ^ m_w[n])));
    return r;
  endfunction

  task automatic cfg_write(input int addr, input logic [IN_W-1:0] data);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = AW'(addr);
    bus.cfg_data = data;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    model_cfg(addr, data);
  endtask

  task automatic drive_beat(input logic [IN_W-1:0] d);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    #1;
    while (bus.in_ready !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t == 20) chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_beats(input logic [L-1:0] v, input int first, input int last);
    for (int b = first; b <= last; b++) begin
      drive_beat(v[b*IN_W +: IN_W]);
      if (b < BEATS - 1) begin
        chk("busy_mid_vec", 64'(bus.cfg_busy), 64'd1);
        chk("valid_mid_vec", 64'(bus.out_valid), 64'd0);
      end
    end
  endtask

  task automatic finish_vec(input logic [L-1:0] v, input int hold);
    logic [NEURONS-1:0] eb;
    eb = exp_bits(v);
    chk("out_valid_rise", 64'(bus.out_valid), 64'd1);
    chk("out_data", 64'(bus.out_data), 64'(eb));
`ifdef BNN_LAYER_POPCNT_EN
    chk("out_popcnt", 64'(bus.out_popcnt), 64'(exp_pc(v)));
`endif
    chk("in_ready_hold", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_data", 64'(bus.out_data), 64'(eb));
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
      chk("hold_busy", 64'(bus.cfg_busy), 64'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("in_ready_ack", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("out_valid_drop", 64'(bus.out_valid), 64'd0);
    chk("in_ready_after", 64'(bus.in_ready), 64'd1);
    chk("busy_after", 64'(bus.cfg_busy), 64'd0);
  endtask

  task automatic send_vec(input logic [L-1:0] v, input int hold);
    send_beats(v, 0, BEATS - 1);
    finish_vec(v, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [L-1:0] v;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_busy", 64'(bus.cfg_busy), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef BNN_LAYER_POPCNT_EN
    chk("rst_popcnt", 64'(bus.out_popcnt), 64'd0);
`endif

    // Unconfigured layer: all-zero input matches every zero weight.
    v = '0;
    send_beats(v, 0, BEATS - 1);
    chk("zero_vec_bits", 64'(bus.out_data), 64'hF);
    finish_vec(v, 0);

    for (int b = 0; b < BEATS; b++) cfg_write(b, 8'hFF);
    cfg_write(WORDS, 8'd17);
    send_vec({L{1'b1}}, 0);
    chk("thr17_ones_bit0", 64'(bus.out_data[0]), 64'd1);
    send_vec('0, 1);
    chk("thr17_zeros_bit0", 64'(bus.out_data[0]), 64'd0);

    cfg_write(WORDS, 8'd16);
    send_vec({8'h00, 8'h00, 8'hFF, 8'hFF}, 0);
    chk("thr16_pc16_bit0", 64'(bus.out_data[0]), 64'd1);
    send_vec({8'h00, 8'h00, 8'h7F, 8'hFF}, 0);
    chk("thr16_pc15_bit0", 64'(bus.out_data[0]), 64'd0);

    send_vec(L'($urandom), 5);

    // Mid-vector cfg write must be dropped; all-ones input exposes any weight change.
    v = {L{1'b1}};
    send_beats(v, 0, 1);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = '0;
    bus.cfg_data = 8'h00;
    #1;
    chk("busy_mid_cfg", 64'(bus.cfg_busy), 64'd1);
    chk("in_ready_mid_cfg", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    send_beats(v, 2, BEATS - 1);
    chk("ignored_cfg_bit0", 64'(bus.out_data[0]), 64'd1);
    finish_vec(v, 0);

    bus.cfg_we   = 1'b1;
    bus.cfg_addr = AW'(WORDS);
    bus.cfg_data = 8'd33;
    bus.in_valid = 1'b1;
    bus.in_data  = v[IN_W-1:0];
    #1;
    chk("cfg_wins_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    model_cfg(WORDS, 8'd33);
    send_vec(v, 0);
    chk("cfg_applied_bit0", 64'(bus.out_data[0]), 64'd0);

    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < 3; k++) cfg_write(int'($urandom_range(0, (1 << AW) - 1)), IN_W'($urandom));
      send_vec({$urandom, $urandom} , int'($urandom_range(0, 3)));
    end

    send_beats(L'($urandom), 0, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("midrst_busy", 64'(bus.cfg_busy), 64'd0);
    chk("midrst_valid", 64'(bus.out_valid), 64'd0);
    v = L'($urandom);
    send_vec(v, 1);

    v = L'($urandom);
    send_beats(v, 0, BEATS - 1);
    chk("pre_rst_hold_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b0;
    chk("holdrst_valid", 64'(bus.out_valid), 64'd0);
    chk("holdrst_data", 64'(bus.out_data), 64'd0);
    chk("holdrst_busy", 64'(bus.cfg_busy), 64'd0);
`ifdef BNN_LAYER_POPCNT_EN
    chk("holdrst_popcnt", 64'(bus.out_popcnt), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bnn_layer.md
BNN_LAYER -- requirements
Module: bnn_layer

Interface
REQ-001 Parameter IN_W, default 8, input bits per beat and cfg_data width.
REQ-002 Parameter BEATS, default 4, beats per input vector; vector length L = IN_W*BEATS.
REQ-003 Parameter NEURONS, default 4, neurons evaluated in parallel.
REQ-004 Derived CNT_W = clog2(L+1) SHALL satisfy CNT_W <= IN_W; elaboration SHALL fail otherwise.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 cfg_we  in  1  configuration write strobe.
REQ-008 cfg_addr  in  clog2(NEURONS*BEATS+NEURONS)  word address.
REQ-009 cfg_data  in  IN_W  write data.
REQ-010 cfg_busy  out  1  high while a vector is in flight or a result is held.
REQ-011 in_valid / in_ready  in / out  1 / 1  input beat handshake.
REQ-012 in_data  in  IN_W  input activation bits, 1 = +1, 0 = -1.
REQ-013 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-014 out_data  out  NEURONS  bit n = binary activation of neuron n.

Function
REQ-015 Address map: addr n*BEATS+b = weight word of neuron n, beat b; addr NEURONS*BEATS+n = threshold of neuron n (low CNT_W bits of cfg_data); other addresses ignored.
REQ-016 States: ACC (accepting beats) and HOLD (result valid); beat counter 0..BEATS-1.
REQ-017 cfg write SHALL take effect only when state=ACC and beat counter=0; otherwise ignored with no side effect.
REQ-018 cfg_busy = (state=HOLD) or (beat counter != 0).
REQ-019 in_ready = (state=ACC) and not (cfg_we and beat counter=0); cfg write wins over first beat.
REQ-020 Each accepted beat b: acc[n] += popcount(~(in_data ^ W[n][b])) for every n; beat counter increments.
REQ-021 On acceptance of beat BEATS-1: out_data[n] = (acc[n]+this beat's popcount >= THR[n]), out_valid=1 next cycle, state=HOLD, beat counter wraps to 0, acc cleared.
REQ-022 Latency: out_valid rises exactly one cycle after the final beat handshake.
REQ-023 In HOLD, out_valid and out_data SHALL be held stable until out_valid&&out_ready; next cycle state=ACC, out_valid=0.
REQ-024 No overlap: in_ready=0 throughout HOLD, including the out_ready handshake cycle.
REQ-025 Accumulators CNT_W wide; max L, no overflow.

Reset
REQ-026 On rst: state=ACC, beat counter=0, acc=0, out_valid=0, out_data=0, all weights=0, all thresholds=0.
REQ-027 rst mid-vector or in HOLD SHALL discard partial/held results; next vector starts at beat 0.
REQ-028 rst has priority over every handshake and cfg write in the same cycle.

Configuration
REQ-029 With BNN_LAYER_POPCNT_EN defined, port out_popcnt (out, NEURONS*CNT_W, neuron n at [n*CNT_W +: CNT_W]) SHALL carry the final popcount, registered and held with out_data, reset 0.
REQ-030 Without BNN_LAYER_POPCNT_EN, out_popcnt is absent and function is otherwise identical.

Structure
REQ-031 Package bnn_pkg SHALL hold the state enum, clog2-based width helpers and the address-map base constant (NEURONS*BEATS).
REQ-032 Sub-module bnn_xnor_popcnt (combinational, IN_W-bit XNOR then popcount, clog2(IN_W+1)-bit result) SHALL be instantiated once per neuron by generate.

Verification
REQ-033 After reset, no cfg, 4 beats of 0x00 -> out_data=4'b1111 one cycle after last beat (popcount 32 >= 0).
REQ-034 Neuron 0 weights 0xFF x4, THR0=17; input 0xFF x4 -> bit0=1 (popcount 32); input 0x00 x4 -> bit0=0 (popcount 0).
REQ-035 THR0=16, weights 0xFF; input 0xFF,0xFF,0x00,0x00 -> bit0=1; input 0xFF,0x7F,0x00,0x00 -> bit0=0 (popcount 15).
REQ-036 out_ready low 5 cycles in HOLD -> out_valid=1, out_data stable, in_ready=0; raise out_ready -> out_valid=0 next cycle, next vector accepted.
REQ-037 cfg write to addr 0 after 2 beats -> cfg_busy=1, write ignored, result matches old weights; cfg_we with in_valid at beat 0 -> in_ready=0, write applied.
REQ-038 rst asserted after 2 beats, then 4 fresh beats -> result equals single-vector result from reset values; with BNN_LAYER_POPCNT_EN, out_popcnt matches expected counts in all scenarios.
